// File: rtl/uart_packet_tx.sv
// Packet UART transmitter: sends a DATA_BYTES-byte word as back-to-back 8N1 frames, LSB byte first.
// Define UART_PARITY_EN to insert an even-parity bit before each stop bit (8E1 framing).
module uart_packet_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BYTES   = 2
) (
    input  logic                    iClock,
    input  logic                    iReset,
    input  logic                    iTxSend,
    input  logic [8*DATA_BYTES-1:0] iData,
    output logic                    oTx,
    output logic                    oTxDone,
    output logic                    oBusy
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned ByteW = $clog2(DATA_BYTES) + 1;
    localparam int unsigned DataW = 8 * DATA_BYTES;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [ByteW-1:0] ByteLast = ByteW'(DATA_BYTES - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd4
    } state_e;
`endif

    state_e             state_q, state_d;
    logic [BaudW-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [ByteW-1:0]   byte_q, byte_d;
    logic [DataW-1:0]   shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               bit_end;
    logic [2:0]         next_bit;
    logic [7:0]         cur_byte;

    assign bit_end  = (baud_q == BaudLast);
    assign next_bit = bit_q + 3'd1;
    assign cur_byte = shift_q[7:0];

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            StIdle: begin
                baud_d = '0;
                bit_d  = '0;
                byte_d = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (iTxSend) begin
                    state_d = StStart;
                    shift_d = iData;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            StStart: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end

            StData: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = StParity;
                        tx_d    = ^cur_byte;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = next_bit;
                        tx_d  = cur_byte[next_bit];
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end

`ifdef UART_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = StStop;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
`endif

            StStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_q != ByteLast) begin
                        // Next byte follows immediately with its start bit.
                        byte_d  = byte_q + ByteW'(1);
                        shift_d = shift_q >> 8;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end else begin
                        byte_d  = '0;
                        state_d = StIdle;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                baud_d  = '0;
                bit_d   = '0;
                byte_d  = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign oTx     = tx_q;
    assign oTxDone = done_q;
    assign oBusy   = busy_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Self-checking bench for uart_packet_tx: random packets against a frame-level line model,
// plus ignored-send, mid-frame reset, back-to-back and minimum-baud cases.
module tb_uart_packet_tx;

    localparam int unsigned C  = 4;
    localparam int unsigned DB = 2;
    localparam int unsigned DW = 8 * DB;
`ifdef UART_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif
    localparam int NoGlitch = -10;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_send;
    logic [DW-1:0] data;
    logic          tx, tx_done, busy;

    logic          tx_send2;
    logic [7:0]    data2;
    logic          tx2, tx_done2, busy2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_packet_tx #(.CLKS_PER_BIT(C), .DATA_BYTES(DB)) u_dut (
        .iClock (clk),
        .iReset (rst),
        .iTxSend(tx_send),
        .iData  (data),
        .oTx    (tx),
        .oTxDone(tx_done),
        .oBusy  (busy)
    );

    uart_packet_tx #(.CLKS_PER_BIT(2), .DATA_BYTES(1)) u_dut_min (
        .iClock (clk),
        .iReset (rst),
        .iTxSend(tx_send2),
        .iData  (data2),
        .oTx    (tx2),
        .oTxDone(tx_done2),
        .oBusy  (busy2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line level of bit position idx (0 = start) within one frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Entered at the falling edge right after the accepting edge; returns in the done cycle.
    task automatic check_packet(input logic [DW-1:0] d, input int glitch_at,
                                input logic [DW-1:0] glitch_data);
        for (int k = 0; k < int'(DB * FB * C); k++) begin
            int bitpos = k / int'(C);
            int by     = bitpos / int'(FB);
            int fi     = bitpos % int'(FB);
            if (k == glitch_at) begin
                tx_send = 1'b1;
                data    = glitch_data;
            end else begin
                if (k == glitch_at + 1) tx_send = 1'b0;
                data = DW'($urandom);
            end
            check_eq("line", {31'd0, tx}, {31'd0, frame_bit(d[8*by +: 8], fi)});
            check_eq("busy", {31'd0, busy}, 32'd1);
            check_eq("no_early_done", {31'd0, tx_done}, 32'd0);
            @(negedge clk);
        end
        check_eq("done", {31'd0, tx_done}, 32'd1);
        check_eq("busy_clr", {31'd0, busy}, 32'd0);
        check_eq("idle_line", {31'd0, tx}, 32'd1);
    endtask

    task automatic send_and_check(input logic [DW-1:0] d, input int glitch_at,
                                  input logic [DW-1:0] glitch_data);
        tx_send = 1'b1;
        data    = d;
        @(negedge clk);
        tx_send = 1'b0;
        check_packet(d, glitch_at, glitch_data);
        @(negedge clk);
        check_eq("done_one_cycle", {31'd0, tx_done}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        tx_send  = 1'b0;
        data     = '0;
        tx_send2 = 1'b0;
        data2    = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_tx", {31'd0, tx}, 32'd1);
        check_eq("rst_done", {31'd0, tx_done}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        send_and_check(16'hA55A, NoGlitch, '0);
        send_and_check(16'hA55A, 20, 16'hFFFF);

        for (int n = 0; n < 6; n++) begin
            send_and_check(DW'($urandom), NoGlitch, '0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset during byte 0 data bits drops the packet.
        tx_send = 1'b1;
        data    = 16'h1234;
        @(negedge clk);
        tx_send = 1'b0;
        repeat (3 * C + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_tx", {31'd0, tx}, 32'd1);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < int'(DB * FB * C + 8); k++) begin
            check_eq("post_rst_done", {31'd0, tx_done}, 32'd0);
            check_eq("post_rst_line", {31'd0, tx}, 32'd1);
            @(negedge clk);
        end
        send_and_check(16'h5AA5, NoGlitch, '0);

        // Send held high: second packet starts on the edge after the done cycle.
        tx_send = 1'b1;
        data    = 16'h0001;
        @(negedge clk);
        check_packet(16'h0001, NoGlitch, '0);
        data = 16'h0002;
        @(negedge clk);
        tx_send = 1'b0;
        check_packet(16'h0002, NoGlitch, '0);
        @(negedge clk);
        check_eq("hold_done_one_cycle", {31'd0, tx_done}, 32'd0);

        // Minimum baud divisor, single byte.
        tx_send2 = 1'b1;
        data2    = 8'h00;
        @(negedge clk);
        tx_send2 = 1'b0;
        for (int k = 0; k < int'(FB * 2); k++) begin
            check_eq("min_line", {31'd0, tx2}, {31'd0, frame_bit(8'h00, k / 2)});
            check_eq("min_busy", {31'd0, busy2}, 32'd1);
            check_eq("min_no_early_done", {31'd0, tx_done2}, 32'd0);
            @(negedge clk);
        end
        check_eq("min_done", {31'd0, tx_done2}, 32'd1);
        check_eq("min_busy_clr", {31'd0, busy2}, 32'd0);
        @(negedge clk);
        check_eq("min_done_one_cycle", {31'd0, tx_done2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
